// File: rtl/fetch_align_ctrl.sv
// Fetch alignment buffer: splits 32-bit fetch words into RV32/RV32C instructions.
// Optional build macro: FETCH_ALIGN_ILLEGAL_EN (flags all-zero decompressor results).
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BUF_HW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_gnt,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [15:0] dec_inst16,
    input  logic [31:0] dec_inst32,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic        inst_illegal
);

    localparam int unsigned FW = 16 * BUF_HW;

    logic [15:0]   hw_buf  [BUF_HW];
    logic [15:0]   buf_nxt [BUF_HW];
    logic [FW-1:0] flat;
    logic [FW-1:0] shifted;
    logic [2:0]    hw_cnt;
    logic [2:0]    cnt_nxt;
    logic [2:0]    shift;
    logic [2:0]    keep;
    logic [2:0]    add;
    logic [31:0]   fetch_pc;
    logic [31:0]   cur_pc;
    logic          outstanding;
    logic          drop_ack;
    logic          skip_lo;
    logic          started;
    logic [15:0]   h0;
    logic          is16;
    logic          consume;
    logic          ack_ok;
    logic          fire;
    logic          unused_pc0;

    assign unused_pc0 = redirect_pc[0];

    assign h0      = hw_buf[0];
    assign is16    = (h0[1:0] != 2'b11);
    assign inst_valid = !redirect_valid &&
                        (is16 ? (hw_cnt >= 3'd1)
                              : (hw_cnt >= 3'd2));
    assign consume = inst_valid && inst_ready;
    assign shift   = !consume ? 3'd0 : (is16 ? 3'd1 : 3'd2);
    assign keep    = hw_cnt - shift;
    assign ack_ok  = fetch_ack && outstanding && !drop_ack;
    assign add     = !ack_ok ? 3'd0 : (skip_lo ? 3'd1 : 3'd2);
    assign cnt_nxt = keep + add;

    assign fetch_req  = started && !outstanding &&
                        (hw_cnt <= 3'd2) && !redirect_valid;
    assign fetch_addr = fetch_pc;
    assign fire       = fetch_req && fetch_gnt;

    assign dec_inst16 = h0;
    assign inst_out   = is16 ? dec_inst32 : {hw_buf[1], h0};
    assign inst_pc    = cur_pc;
    assign inst_is_c  = inst_valid && is16;

`ifdef FETCH_ALIGN_ILLEGAL_EN
    assign inst_illegal = inst_valid && is16 &&
                          (dec_inst32 == 32'b0);
`else
    assign inst_illegal = 1'b0;
`endif

    // Drop consumed halfwords, then append returned ones at the new tail.
    always_comb begin
        for (int i = 0; i < BUF_HW; i++) begin
            flat[16*i +: 16] = hw_buf[i];
        end
        shifted = flat >> {shift, 4'b0000};
        for (int i = 0; i < BUF_HW; i++) begin
            buf_nxt[i] = shifted[16*i +: 16];
            if (ack_ok) begin
                if (skip_lo) begin
                    if (3'(i) == keep) begin
                        buf_nxt[i] = fetch_data[31:16];
                    end
                end else begin
                    if (3'(i) == keep) begin
                        buf_nxt[i] = fetch_data[15:0];
                    end
                    if (3'(i) == keep + 3'd1) begin
                        buf_nxt[i] = fetch_data[31:16];
                    end
                end
            end
        end
    end

    // Buffer, PCs and fetch bookkeeping; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_HW; i++) begin
                hw_buf[i] <= 16'h0000;
            end
            hw_cnt      <= 3'd0;
            outstanding <= 1'b0;
            drop_ack    <= 1'b0;
            skip_lo     <= RESET_PC[1];
            cur_pc      <= RESET_PC;
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            started     <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                hw_cnt      <= 3'd0;
                cur_pc      <= {redirect_pc[31:1], 1'b0};
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                skip_lo     <= redirect_pc[1];
                outstanding <= outstanding && !fetch_ack;
                drop_ack    <= outstanding && !fetch_ack;
            end else begin
                hw_buf <= buf_nxt;
                hw_cnt <= cnt_nxt;
                cur_pc <= cur_pc + {28'b0, shift, 1'b0};
                if (fire) begin
                    outstanding <= 1'b1;
                    fetch_pc    <= fetch_pc + 32'd4;
                end else if (fetch_ack && outstanding) begin
                    outstanding <= 1'b0;
                    drop_ack    <= 1'b0;
                end
                if (ack_ok && skip_lo) begin
                    skip_lo <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Randomized bench for fetch_align_ctrl against a program-order model.
// Memory, decompressor and instruction stream are modelled behaviourally.
module tb_fetch_align_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic [15:0] dec_inst16;
    logic [31:0] dec_inst32;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic        inst_illegal;

    always #5 clk = ~clk;

    fetch_align_ctrl #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_gnt     (fetch_gnt),
        .fetch_ack     (fetch_ack),
        .fetch_data    (fetch_data),
        .dec_inst16    (dec_inst16),
        .dec_inst32    (dec_inst32),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_is_c     (inst_is_c),
        .inst_illegal  (inst_illegal)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    logic [31:0] mem [256];

    function automatic logic [15:0] mem16(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] dec_model(input logic [15:0] h);
        case (h)
            16'h4501: return 32'h0000_0513;
            16'h0001: return 32'h0000_0013;
            16'h0000: return 32'h0000_0000;
            default:  return {~h, h};
        endcase
    endfunction

    assign dec_inst32 = dec_model(dec_inst16);

    logic [31:0] mpc;
    logic [31:0] exp_faddr;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          n_cons;
    logic        dir_done;
    logic        stall;
    logic [15:0] h;
    logic [31:0] e_out;
    logic        e_c;
    logic        e_ill;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]     = 32'h0000_4501;
        mem[1]     = 32'h0000_0513;
        mem[2]     = 32'h0513_0001;
        mem[3]     = 32'h0001_0000;
        mem[4]     = 32'h0001_0000;
        mem[8'h41] = 32'h4501_1111;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fetch_gnt      = 1'b0;
        fetch_ack      = 1'b0;
        fetch_data     = 32'h0;
        inst_ready     = 1'b0;
        mpc       = 32'h0;
        exp_faddr = 32'h0;
        pend      = 1'b0;
        pend_addr = 32'h0;
        pend_wait = 0;
        n_cons    = 0;
        dir_done  = 1'b0;

        #12;
        chk("rst_valid", inst_valid, 0);
        chk("rst_req", fetch_req, 0);
        chk("rst_is_c", inst_is_c, 0);
        chk("rst_ill", inst_illegal, 0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_faddr", fetch_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            fetch_ack  = 1'b0;
            fetch_data = $urandom;
            if (pend && pend_wait == 0) begin
                fetch_ack  = 1'b1;
                fetch_data = mem[pend_addr[9:2]];
            end else if (pend) begin
                pend_wait--;
            end else if ($urandom_range(0, 15) == 0) begin
                fetch_ack = 1'b1;
            end

            stall = (cyc >= 40 && cyc < 60);
            inst_ready = stall ? 1'b0
                               : ($urandom_range(0, 3) != 0);
            redirect_valid = 1'b0;
            if (cyc >= 60 && cyc < 80 && !dir_done &&
                pend && !fetch_ack) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0106;
                dir_done       = 1'b1;
            end else if (cyc >= 80 &&
                         $urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                if ($urandom_range(0, 7) == 0)
                    redirect_pc[31:3] = '1;
            end
            #1;

            if (redirect_valid)
                chk("valid_in_redir", inst_valid, 0);
            if (cyc == 59) begin
                chk("stall_req", fetch_req, 0);
                chk("stall_valid", inst_valid, 1);
            end
            if (cyc == 80)
                chk("dir_redir", dir_done, 1);

            if (inst_valid) begin
                h = mem16(mpc);
                if (h[1:0] != 2'b11) begin
                    e_out = dec_model(h);
                    e_c   = 1'b1;
                end else begin
                    e_out = {mem16(mpc + 32'd2), h};
                    e_c   = 1'b0;
                end
`ifdef FETCH_ALIGN_ILLEGAL_EN
                e_ill = e_c && (e_out == 32'h0);
`else
                e_ill = 1'b0;
`endif
                chk("inst_pc", inst_pc, mpc);
                chk("inst_out", inst_out, e_out);
                chk("inst_is_c", inst_is_c, e_c);
                chk("inst_ill", inst_illegal, e_ill);
                if (inst_ready) begin
                    mpc = mpc + (e_c ? 32'd2 : 32'd4);
                    n_cons++;
                end
            end

            fetch_gnt = stall ? 1'b1
                              : ($urandom_range(0, 3) != 0);
            if (fetch_req) begin
                chk("one_out", pend, 0);
                if (fetch_gnt) begin
                    chk("faddr", fetch_addr, exp_faddr);
                    exp_faddr = exp_faddr + 32'd4;
                end
            end
            if (fetch_ack && pend) pend = 1'b0;
            if (fetch_req && fetch_gnt) begin
                pend      = 1'b1;
                pend_addr = fetch_addr;
                pend_wait = (cyc >= 60 && cyc < 80)
                          ? 2 : $urandom_range(0, 2);
            end
            if (redirect_valid) begin
                mpc       = redirect_pc & ~32'd1;
                exp_faddr = redirect_pc & ~32'd3;
            end
        end

        chk("progress", n_cons > 300, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
